// File: rtl/mul_share_arbiter.sv
// Round-robin sequencer that shares one eval/done multiplier among NREQ requesters.
// Operands are latched at grant; a watchdog turns a silent unit into an error response.
module mul_share_arbiter #(
    parameter int NREQ    = 4,
    parameter int MANT_W  = 34,
    parameter int EXP_W   = 7,
    parameter int TIMEOUT = 64
) (
    input  logic                    clock_i,
    input  logic                    reset_i,
    input  logic [NREQ-1:0]         req_i,
    input  logic [NREQ-1:0]         req_sign_a_i,
    input  logic [NREQ*MANT_W-1:0]  req_mant_a_i,
    input  logic [NREQ*EXP_W-1:0]   req_exp_a_i,
    input  logic [NREQ-1:0]         req_sign_b_i,
    input  logic [NREQ*MANT_W-1:0]  req_mant_b_i,
    input  logic [NREQ*EXP_W-1:0]   req_exp_b_i,
    output logic                    u_eval_o,
    output logic                    u_sign_a_o,
    output logic [MANT_W-1:0]       u_mant_a_o,
    output logic [EXP_W-1:0]        u_exp_a_o,
    output logic                    u_sign_b_o,
    output logic [MANT_W-1:0]       u_mant_b_o,
    output logic [EXP_W-1:0]        u_exp_b_o,
    input  logic                    u_done_i,
    input  logic                    u_sign_res_i,
    input  logic [MANT_W-1:0]       u_mant_res_i,
    input  logic [EXP_W-1:0]        u_exp_res_i,
    output logic [NREQ-1:0]         grant_o,
    output logic [NREQ-1:0]         resp_done_o,
    output logic                    resp_err_o,
    output logic                    res_sign_o,
    output logic [MANT_W-1:0]       res_mant_o,
    output logic [EXP_W-1:0]        res_exp_o,
    output logic                    busy_o
);
    localparam int IDX_W = $clog2(NREQ);
    localparam int CNT_W = $clog2(TIMEOUT) + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_WAIT,
        ST_RESP
    } state_e;

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  last_q, last_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [NREQ-1:0]   grant_q, grant_d;
    logic [NREQ-1:0]   resp_done_q, resp_done_d;
    logic              resp_err_q, resp_err_d;
    logic              u_eval_q, u_eval_d;
    logic              u_sign_a_q, u_sign_a_d, u_sign_b_q, u_sign_b_d;
    logic [MANT_W-1:0] u_mant_a_q, u_mant_a_d, u_mant_b_q, u_mant_b_d;
    logic [EXP_W-1:0]  u_exp_a_q, u_exp_a_d, u_exp_b_q, u_exp_b_d;
    logic              res_sign_q, res_sign_d;
    logic [MANT_W-1:0] res_mant_q, res_mant_d;
    logic [EXP_W-1:0]  res_exp_q, res_exp_d;

    logic [MANT_W-1:0] mant_a_arr [NREQ];
    logic [MANT_W-1:0] mant_b_arr [NREQ];
    logic [EXP_W-1:0]  exp_a_arr  [NREQ];
    logic [EXP_W-1:0]  exp_b_arr  [NREQ];

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign mant_a_arr[gi] = req_mant_a_i[gi*MANT_W +: MANT_W];
            assign mant_b_arr[gi] = req_mant_b_i[gi*MANT_W +: MANT_W];
            assign exp_a_arr[gi]  = req_exp_a_i[gi*EXP_W +: EXP_W];
            assign exp_b_arr[gi]  = req_exp_b_i[gi*EXP_W +: EXP_W];
        end
    endgenerate

    // Search starts just past the previous winner and wraps, giving round-robin order.
    logic [IDX_W-1:0] win, scan;
    logic             found;

    always_comb begin
        win   = last_q;
        scan  = last_q;
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            scan = (scan == IDX_W'(NREQ - 1)) ? '0 : scan + IDX_W'(1);
            if (!found && req_i[scan]) begin
                found = 1'b1;
                win   = scan;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        grant_d     = grant_q;
        resp_done_d = resp_done_q;
        resp_err_d  = resp_err_q;
        u_eval_d    = u_eval_q;
        u_sign_a_d  = u_sign_a_q;
        u_mant_a_d  = u_mant_a_q;
        u_exp_a_d   = u_exp_a_q;
        u_sign_b_d  = u_sign_b_q;
        u_mant_b_d  = u_mant_b_q;
        u_exp_b_d   = u_exp_b_q;
        res_sign_d  = res_sign_q;
        res_mant_d  = res_mant_q;
        res_exp_d   = res_exp_q;

        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    u_sign_a_d   = req_sign_a_i[win];
                    u_mant_a_d   = mant_a_arr[win];
                    u_exp_a_d    = exp_a_arr[win];
                    u_sign_b_d   = req_sign_b_i[win];
                    u_mant_b_d   = mant_b_arr[win];
                    u_exp_b_d    = exp_b_arr[win];
                    grant_d      = '0;
                    grant_d[win] = 1'b1;
                    last_d       = win;
                    state_d      = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                u_eval_d = 1'b1;
                cnt_d    = '0;
                state_d  = ST_WAIT;
            end
            ST_WAIT: begin
                u_eval_d = 1'b0;
                // A completion on the expiry cycle still counts as a good result.
                if (u_done_i) begin
                    res_sign_d  = u_sign_res_i;
                    res_mant_d  = u_mant_res_i;
                    res_exp_d   = u_exp_res_i;
                    resp_err_d  = 1'b0;
                    resp_done_d = grant_q;
                    state_d     = ST_RESP;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    res_sign_d  = 1'b0;
                    res_mant_d  = '0;
                    res_exp_d   = '0;
                    resp_err_d  = 1'b1;
                    resp_done_d = grant_q;
                    state_d     = ST_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RESP: begin
                resp_done_d = '0;
                resp_err_d  = 1'b0;
                grant_d     = '0;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= ST_IDLE;
            last_q      <= IDX_W'(NREQ - 1);
            cnt_q       <= '0;
            grant_q     <= '0;
            resp_done_q <= '0;
            resp_err_q  <= 1'b0;
            u_eval_q    <= 1'b0;
            u_sign_a_q  <= 1'b0;
            u_mant_a_q  <= '0;
            u_exp_a_q   <= '0;
            u_sign_b_q  <= 1'b0;
            u_mant_b_q  <= '0;
            u_exp_b_q   <= '0;
            res_sign_q  <= 1'b0;
            res_mant_q  <= '0;
            res_exp_q   <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            grant_q     <= grant_d;
            resp_done_q <= resp_done_d;
            resp_err_q  <= resp_err_d;
            u_eval_q    <= u_eval_d;
            u_sign_a_q  <= u_sign_a_d;
            u_mant_a_q  <= u_mant_a_d;
            u_exp_a_q   <= u_exp_a_d;
            u_sign_b_q  <= u_sign_b_d;
            u_mant_b_q  <= u_mant_b_d;
            u_exp_b_q   <= u_exp_b_d;
            res_sign_q  <= res_sign_d;
            res_mant_q  <= res_mant_d;
            res_exp_q   <= res_exp_d;
        end
    end

    assign u_eval_o    = u_eval_q;
    assign u_sign_a_o  = u_sign_a_q;
    assign u_mant_a_o  = u_mant_a_q;
    assign u_exp_a_o   = u_exp_a_q;
    assign u_sign_b_o  = u_sign_b_q;
    assign u_mant_b_o  = u_mant_b_q;
    assign u_exp_b_o   = u_exp_b_q;
    assign grant_o     = grant_q;
    assign resp_done_o = resp_done_q;
    assign resp_err_o  = resp_err_q;
    assign res_sign_o  = res_sign_q;
    assign res_mant_o  = res_mant_q;
    assign res_exp_o   = res_exp_q;
    assign busy_o      = (state_q != ST_IDLE);

endmodule
